// File: rtl/pc_reg.sv
// pc_reg: fetch-stage program counter that steps sequentially or loads a redirect target
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk)
        pc_o <= !rst_ ? RESET_PC : jump_flag_i ? jump_addr_i : pc_o + PC_STEP;
endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: directed vector table plus randomized run against a base-plus-steps model
module tb_pc_reg;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [31:0] pc_o;
    int total = 0;
    int bad = 0;

    pc_reg dut (
        .clk(clk),
        .rst_(rst_),
        .jump_flag_i(jump_flag_i),
        .jump_addr_i(jump_addr_i),
        .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        j;
        logic [31:0] a;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic step(input logic r, input logic j, input logic [31:0] a);
        @(negedge clk);
        rst_ = r;
        jump_flag_i = j;
        jump_addr_i = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] exp);
        total++;
        if (pc_o !== exp) begin
            bad++;
            $display("FAIL %s: pc_o=%h expected=%h", name, pc_o, exp);
        end
    endtask

    // Reference: PC is the last load point plus four bytes per edge since then.
    logic [31:0] base;
    int unsigned steps;

    initial begin
        vec_t v[$];
        v.push_back('{1'b0, 1'b0, 32'h0,          32'h0000_0000, "reset"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_0004, "first_step"});
        v.push_back('{1'b0, 1'b0, 32'h0,          32'h0000_0000, "mid_reset"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_0004, "resume_1"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_0008, "resume_2"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_000C, "resume_3"});
        v.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF, "jump_unaligned"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'hDEAD_BEF3, "unaligned_step1"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'hDEAD_BEF7, "unaligned_step2"});
        v.push_back('{1'b0, 1'b1, 32'h0000_1000,  32'h0000_0000, "reset_over_jump"});
        v.push_back('{1'b1, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, "jump_top"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_0000, "wrap"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_0004, "after_wrap"});
        v.push_back('{1'b1, 1'b1, 32'h0000_0100,  32'h0000_0100, "hold_jump_1"});
        v.push_back('{1'b1, 1'b1, 32'h0000_0200,  32'h0000_0200, "hold_jump_2"});
        v.push_back('{1'b1, 1'b1, 32'h0000_0300,  32'h0000_0300, "hold_jump_3"});
        v.push_back('{1'b1, 1'b0, 32'h0,          32'h0000_0304, "release_jump"});
        v.push_back('{1'b1, 1'b1, 32'h0000_0300,  32'h0000_0300, "same_addr_jump_1"});
        v.push_back('{1'b1, 1'b1, 32'h0000_0300,  32'h0000_0300, "same_addr_jump_2"});
        foreach (v[i]) begin
            step(v[i].r, v[i].j, v[i].a);
            check(v[i].name, v[i].exp);
        end

        base = 32'h0000_0300;
        steps = 0;
        for (int i = 0; i < 400; i++) begin
            logic        r, j;
            logic [31:0] a;
            r = ($urandom_range(15) != 0);
            j = ($urandom_range(3) == 0);
            a = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
            step(r, j, a);
            if (!r) begin
                base = 32'h0;
                steps = 0;
            end else if (j) begin
                base = a;
                steps = 0;
            end else
                steps++;
            check("random", base + 32'(steps * 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
